amba_axi4_stream_reg_slice: RTL and testbench
=============================================

// Module: amba_axi4_stream_reg_slice
// PURPOSE
//  Full AXI4-Stream register slice (two-entry skid buffer) placed between a stream source and sink.
//  Breaks combinational paths on TVALID/payload (forward) and TREADY (backward) with zero bubbles.
//  S_ side consumes an upstream source; M_ side drives a downstream sink.
//  Both sides must pass the amba_axi4_stream_seda source/sink checks.
// PARAMETERS
//  STATS_W          32  width of optional beat/packet counters (only with AXIS_REG_SLICE_STATS_EN)
//  ZERO_IDLE_PAYLOAD 0  1: M_ payload forced to 0 whenever M_TVALID=0; 0: payload holds last value
// PORTS
//  ACLK       in   1        clock, all logic rising-edge
//  ARESETn    in   1        asynchronous active-low reset
//  S_TDATA    in   axi_data_t   upstream payload (likewise S_TSTRB/S_TKEEP/S_TLAST/S_TID/S_TDEST/S_TUSER, pkg types)
//  S_TVALID   in   1        upstream valid
//  S_TREADY   out  1        registered ready to upstream
//  M_TDATA    out  axi_data_t   downstream payload (likewise M_TSTRB/M_TKEEP/M_TLAST/M_TID/M_TDEST/M_TUSER)
//  M_TVALID   out  1        registered valid to downstream
//  M_TREADY   in   1        downstream ready
//  beat_cnt   out  STATS_W  [STATS_EN only] beats accepted on M side
//  pkt_cnt    out  STATS_W  [STATS_EN only] M-side beats with TLAST=1
// BEHAVIOUR
//  - Reset (async assert, sync release): M_TVALID=0, S_TREADY=0, state=EMPTY, main/skid payload regs=0,
//    counters=0. S_TREADY rises on the first ACLK edge after ARESETn release. No output changes combinationally.
//  - s_hs = S_TVALID&S_TREADY; m_hs = M_TVALID&M_TREADY. Latency S->M: 1 cycle when EMPTY.
//  - States (slice_state_t): EMPTY (0 held), BUSY (main valid), FULL (main+skid valid).
//    EMPTY: s_hs -> main<=S, BUSY.
//    BUSY : s_hs&!m_hs -> skid<=S, FULL; m_hs&!s_hs -> EMPTY; s_hs&m_hs -> main<=S, BUSY; else hold.
//    FULL : m_hs -> main<=skid, BUSY. s_hs impossible (S_TREADY=0).
//  - Registered outputs: M_TVALID = (state!=EMPTY); S_TREADY = (state!=FULL) (0 during/at reset).
//  - M payload stable while M_TVALID&!M_TREADY (AXI4-Stream rule); M_TVALID never drops without m_hs.
//  - Ordering strictly FIFO; all sideband fields travel with TDATA as one packed axis_payload_t.
//  - Throughput: 1 beat/cycle sustained with M_TREADY=1; no bubble on BUSY->FULL->BUSY transitions.
//  - Reset mid-transfer: all held beats discarded, no partial packet replay.
//  - S_TVALID/payload ignored while S_TREADY=0 (no capture, no X propagation into state).
// CONFIGURATION
//  - `AXIS_REG_SLICE_STATS_EN defined: beat_cnt/pkt_cnt ports exist; increment on m_hs (pkt_cnt when M_TLAST),
//    saturate at all-ones, cleared only by reset.
//  - Not defined: ports and counter logic absent; datapath identical.
// STRUCTURE
//  - amba_axi4_stream_seda_pkg: reuse axi_*_t types; add axis_payload_t packed struct and
//    slice_state_t enum {EMPTY,BUSY,FULL}.
//  - One sub-module: amba_axi4_stream_slice_stats (saturating counters), instantiated only under the macro.
// TESTING
//  - Reset release, S_TVALID=1 TDATA=0xA5 TLAST=1, M_TREADY=1 -> S_TREADY=1 cycle 1; M_TVALID/0xA5 next cycle.
//  - Stream 0x01..0x10 with M_TREADY=1 -> 16 beats out in order, one per cycle, no gaps.
//  - M_TREADY=0 while sending 0x11,0x22,0x33 -> FULL after 2 beats, S_TREADY=0, 0x33 held upstream,
//    M_TDATA stable at 0x11; release -> 0x11,0x22,0x33 back-to-back.
//  - ARESETn low in FULL -> M_TVALID=0, S_TREADY=0 immediately; no stale beat after release.
//  - STATS_EN, STATS_W=4: 20 beats, every 4th TLAST -> beat_cnt=15 (saturated), pkt_cnt=5.
//  - Formal: bind amba_axi4_stream_seda VERIFY_SOURCE on M_, VERIFY_SINK on S_ (constraints) -> all pass.

Source files
------------

// File: rtl/amba_axi4_stream_seda_pkg.sv
// ============================================================================
// Module      : amba_axi4_stream_seda_pkg
// Description : Shared AXI4-Stream field types, the packed beat payload
//               carried through the register slice, and the slice state enum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package amba_axi4_stream_seda_pkg;

  localparam int c_data_w = 32;
  localparam int c_id_w   = 4;
  localparam int c_dest_w = 4;
  localparam int c_user_w = 8;

  typedef logic [c_data_w-1:0]   axi_data_t;
  typedef logic [c_data_w/8-1:0] axi_strb_t;
  typedef logic [c_data_w/8-1:0] axi_keep_t;
  typedef logic                  axi_last_t;
  typedef logic [c_id_w-1:0]     axi_id_t;
  typedef logic [c_dest_w-1:0]   axi_dest_t;
  typedef logic [c_user_w-1:0]   axi_user_t;

  // Every sideband field travels with TDATA as one unit.
  typedef struct packed {
    axi_data_t tdata;
    axi_strb_t tstrb;
    axi_keep_t tkeep;
    axi_last_t tlast;
    axi_id_t   tid;
    axi_dest_t tdest;
    axi_user_t tuser;
  } axis_payload_t;

  // EMPTY: nothing held, BUSY: main valid, FULL: main and skid valid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } slice_state_t;

endpackage

`default_nettype wire

// File: rtl/amba_axi4_stream_slice_stats.sv
// ============================================================================
// Module      : amba_axi4_stream_slice_stats
// Description : Saturating beat and packet counters for the output side of
//               the AXI4-Stream register slice. Cleared only by reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module amba_axi4_stream_slice_stats #(
  parameter int STATS_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_beat,
  input  logic               i_last,
  output logic [STATS_W-1:0] o_beat_cnt,
  output logic [STATS_W-1:0] o_pkt_cnt
);

  logic [STATS_W-1:0] r_beat_cnt;
  logic [STATS_W-1:0] r_pkt_cnt;

  // Count accepted beats and TLAST beats, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_cnt <= '0;
      r_pkt_cnt  <= '0;
    end else begin
      if (i_beat && (r_beat_cnt != '1)) begin
        r_beat_cnt <= r_beat_cnt + STATS_W'(1);
      end
      if (i_beat && i_last && (r_pkt_cnt != '1)) begin
        r_pkt_cnt <= r_pkt_cnt + STATS_W'(1);
      end
    end
  end

  assign o_beat_cnt = r_beat_cnt;
  assign o_pkt_cnt  = r_pkt_cnt;

endmodule

`default_nettype wire

// File: rtl/amba_axi4_stream_reg_slice.sv
// ============================================================================
// Module      : amba_axi4_stream_reg_slice
// Description : Full AXI4-Stream register slice built as a two-entry skid
//               buffer. TVALID, payload and TREADY are all driven from flops,
//               sustaining one beat per cycle with no bubbles.
//               Optional feature macro: AXIS_REG_SLICE_STATS_EN adds the
//               beat_cnt / pkt_cnt saturating counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module amba_axi4_stream_reg_slice
  import amba_axi4_stream_seda_pkg::*;
#(
  parameter int STATS_W           = 32,
  parameter bit ZERO_IDLE_PAYLOAD = 1'b0
) (
  input  logic               ACLK,
  input  logic               ARESETn,
  input  axi_data_t          S_TDATA,
  input  axi_strb_t          S_TSTRB,
  input  axi_keep_t          S_TKEEP,
  input  axi_last_t          S_TLAST,
  input  axi_id_t            S_TID,
  input  axi_dest_t          S_TDEST,
  input  axi_user_t          S_TUSER,
  input  logic               S_TVALID,
  output logic               S_TREADY,
  output axi_data_t          M_TDATA,
  output axi_strb_t          M_TSTRB,
  output axi_keep_t          M_TKEEP,
  output axi_last_t          M_TLAST,
  output axi_id_t            M_TID,
  output axi_dest_t          M_TDEST,
  output axi_user_t          M_TUSER,
  output logic               M_TVALID,
  input  logic               M_TREADY
`ifdef AXIS_REG_SLICE_STATS_EN
  ,
  output logic [STATS_W-1:0] beat_cnt,
  output logic [STATS_W-1:0] pkt_cnt
`endif
);

  slice_state_t  r_state;
  slice_state_t  w_state_nxt;
  axis_payload_t r_main;
  axis_payload_t r_skid;
  axis_payload_t w_s_payload;
  axis_payload_t w_m_payload;
  logic          r_m_valid;
  logic          r_s_ready;
  logic          w_s_hs;
  logic          w_m_hs;
  logic          w_load_main;
  logic          w_load_skid;
  logic          w_main_from_skid;

  assign w_s_payload = '{tdata: S_TDATA, tstrb: S_TSTRB, tkeep: S_TKEEP,
                         tlast: S_TLAST, tid: S_TID, tdest: S_TDEST,
                         tuser: S_TUSER};

  // S_TVALID is gated by our own ready, so nothing is captured while stalled.
  assign w_s_hs = S_TVALID & r_s_ready;
  assign w_m_hs = r_m_valid & M_TREADY;

  // Next-state and register-load decode for the skid buffer.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main      = 1'b0;
    w_load_skid      = 1'b0;
    w_main_from_skid = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_s_hs) begin
          w_load_main = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (w_s_hs && !w_m_hs) begin
          w_load_skid = 1'b1;
          w_state_nxt = FULL;
        end else if (!w_s_hs && w_m_hs) begin
          w_state_nxt = EMPTY;
        end else if (w_s_hs && w_m_hs) begin
          w_load_main = 1'b1;
        end
      end
      FULL: begin
        if (w_m_hs) begin
          w_main_from_skid = 1'b1;
          w_state_nxt      = BUSY;
        end
      end
      default: begin
        w_state_nxt = EMPTY;
      end
    endcase
  end

  // State plus registered handshake outputs; ready stays low through reset.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state   <= EMPTY;
      r_m_valid <= 1'b0;
      r_s_ready <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_m_valid <= (w_state_nxt != EMPTY);
      r_s_ready <= (w_state_nxt != FULL);
    end
  end

  // Main/skid payload storage; main refills from skid to keep FIFO order.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_main) begin
        r_main <= w_s_payload;
      end else if (w_main_from_skid) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_s_payload;
      end
    end
  end

  generate
    if (ZERO_IDLE_PAYLOAD) begin : g_zero_idle
      assign w_m_payload = r_m_valid ? r_main : '0;
    end else begin : g_hold_idle
      assign w_m_payload = r_main;
    end
  endgenerate

  assign S_TREADY = r_s_ready;
  assign M_TVALID = r_m_valid;
  assign M_TDATA  = w_m_payload.tdata;
  assign M_TSTRB  = w_m_payload.tstrb;
  assign M_TKEEP  = w_m_payload.tkeep;
  assign M_TLAST  = w_m_payload.tlast;
  assign M_TID    = w_m_payload.tid;
  assign M_TDEST  = w_m_payload.tdest;
  assign M_TUSER  = w_m_payload.tuser;

`ifdef AXIS_REG_SLICE_STATS_EN
  amba_axi4_stream_slice_stats #(
    .STATS_W (STATS_W)
  ) u_stats (
    .clk        (ACLK),
    .rst_n      (ARESETn),
    .i_beat     (w_m_hs),
    .i_last     (w_m_payload.tlast),
    .o_beat_cnt (beat_cnt),
    .o_pkt_cnt  (pkt_cnt)
  );
`else
  localparam int c_stats_w_unused = STATS_W;
`endif

endmodule

`default_nettype wire

// File: tb/tb_amba_axi4_stream_reg_slice.sv
// ============================================================================
// Module      : tb_amba_axi4_stream_reg_slice
// Description : Directed self-checking bench for the AXI4-Stream register
//               slice. Inputs change 1 time unit after the rising edge and
//               outputs are sampled on the falling edge.
//               Optional feature macro: AXIS_REG_SLICE_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_amba_axi4_stream_reg_slice;
  import amba_axi4_stream_seda_pkg::*;

  logic      ACLK;
  logic      ARESETn;
  axi_data_t S_TDATA;
  axi_strb_t S_TSTRB;
  axi_keep_t S_TKEEP;
  axi_last_t S_TLAST;
  axi_id_t   S_TID;
  axi_dest_t S_TDEST;
  axi_user_t S_TUSER;
  logic      S_TVALID;
  logic      S_TREADY;
  axi_data_t M_TDATA;
  axi_strb_t M_TSTRB;
  axi_keep_t M_TKEEP;
  axi_last_t M_TLAST;
  axi_id_t   M_TID;
  axi_dest_t M_TDEST;
  axi_user_t M_TUSER;
  logic      M_TVALID;
  logic      M_TREADY;
`ifdef AXIS_REG_SLICE_STATS_EN
  logic [3:0] beat_cnt;
  logic [3:0] pkt_cnt;
`endif

  int n_pass;
  int n_total;

  amba_axi4_stream_reg_slice #(
    .STATS_W           (4),
    .ZERO_IDLE_PAYLOAD (1'b0)
  ) dut (
    .ACLK     (ACLK),
    .ARESETn  (ARESETn),
    .S_TDATA  (S_TDATA),
    .S_TSTRB  (S_TSTRB),
    .S_TKEEP  (S_TKEEP),
    .S_TLAST  (S_TLAST),
    .S_TID    (S_TID),
    .S_TDEST  (S_TDEST),
    .S_TUSER  (S_TUSER),
    .S_TVALID (S_TVALID),
    .S_TREADY (S_TREADY),
    .M_TDATA  (M_TDATA),
    .M_TSTRB  (M_TSTRB),
    .M_TKEEP  (M_TKEEP),
    .M_TLAST  (M_TLAST),
    .M_TID    (M_TID),
    .M_TDEST  (M_TDEST),
    .M_TUSER  (M_TUSER),
    .M_TVALID (M_TVALID),
    .M_TREADY (M_TREADY)
`ifdef AXIS_REG_SLICE_STATS_EN
    ,
    .beat_cnt (beat_cnt),
    .pkt_cnt  (pkt_cnt)
`endif
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic test_reset();
    ARESETn  = 1'b0;
    S_TVALID = 1'b0;
    S_TDATA  = '0;
    S_TSTRB  = '1;
    S_TKEEP  = '1;
    S_TLAST  = 1'b0;
    S_TID    = '0;
    S_TDEST  = 4'h3;
    S_TUSER  = 8'h5C;
    M_TREADY = 1'b0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    n_total++; if (M_TVALID !== 1'b0) $display("FAIL reset_m_tvalid: got %b want 0", M_TVALID); else n_pass++;
    n_total++; if (S_TREADY !== 1'b0) $display("FAIL reset_s_tready: got %b want 0", S_TREADY); else n_pass++;
    n_total++; if (M_TDATA !== 32'h0 || M_TLAST !== 1'b0) $display("FAIL reset_payload: got %h/%b want 0/0", M_TDATA, M_TLAST); else n_pass++;
  endtask

  task automatic test_first_beat();
    @(posedge ACLK); #1;
    ARESETn  = 1'b1;
    S_TVALID = 1'b1;
    S_TDATA  = 32'hA5;
    S_TLAST  = 1'b1;
    M_TREADY = 1'b1;
    @(negedge ACLK);
    n_total++; if (S_TREADY !== 1'b0) $display("FAIL first_ready_before_edge: got %b want 0", S_TREADY); else n_pass++;
    @(negedge ACLK);
    n_total++; if (S_TREADY !== 1'b1 || M_TVALID !== 1'b0) $display("FAIL first_ready_rise: got rdy=%b vld=%b want 1/0", S_TREADY, M_TVALID); else n_pass++;
    @(posedge ACLK); #1;
    S_TVALID = 1'b0;
    S_TLAST  = 1'b0;
    S_TDATA  = '0;
    @(negedge ACLK);
    n_total++; if (M_TVALID !== 1'b1 || M_TDATA !== 32'hA5 || M_TLAST !== 1'b1 || M_TUSER !== 8'h5C) $display("FAIL first_beat_out: got vld=%b data=%h last=%b user=%h want 1/a5/1/5c", M_TVALID, M_TDATA, M_TLAST, M_TUSER); else n_pass++;
    @(negedge ACLK);
    n_total++; if (M_TVALID !== 1'b0 || M_TDATA !== 32'hA5) $display("FAIL first_drain_hold: got vld=%b data=%h want 0/a5", M_TVALID, M_TDATA); else n_pass++;
  endtask

  task automatic test_stream();
    int idx;
    int got;
    int gaps;
    idx  = 0;
    got  = 0;
    gaps = 0;
    M_TREADY = 1'b1;
    @(posedge ACLK); #1;
    S_TVALID = 1'b1;
    S_TDATA  = 32'(idx + 1);
    S_TID    = 4'(idx);
    S_TLAST  = (idx == 15);
    for (int cyc = 0; cyc < 40 && got < 16; cyc++) begin
      @(negedge ACLK);
      if (M_TVALID && M_TREADY) begin
        n_total++;
        if (M_TDATA !== 32'(got + 1) || M_TID !== 4'(got) || M_TLAST !== (got == 15))
          $display("FAIL stream_beat%0d: got data=%h id=%h last=%b want %h/%h/%b", got, M_TDATA, M_TID, M_TLAST, got + 1, got[3:0], got == 15);
        else
          n_pass++;
        got++;
      end else if (got > 0) begin
        gaps++;
      end
      if (S_TVALID && S_TREADY) idx++;
      @(posedge ACLK); #1;
      if (idx < 16) begin
        S_TVALID = 1'b1;
        S_TDATA  = 32'(idx + 1);
        S_TID    = 4'(idx);
        S_TLAST  = (idx == 15);
      end else begin
        S_TVALID = 1'b0;
        S_TLAST  = 1'b0;
      end
    end
    n_total++; if (got !== 16) $display("FAIL stream_count: got %0d beats want 16", got); else n_pass++;
    n_total++; if (gaps !== 0) $display("FAIL stream_gaps: got %0d idle cycles want 0", gaps); else n_pass++;
  endtask

  task automatic test_backpressure();
    M_TREADY = 1'b0;
    S_TVALID = 1'b1;
    S_TID    = '0;
    S_TLAST  = 1'b0;
    S_TDATA  = 32'h11;
    @(posedge ACLK); #1;
    S_TDATA = 32'h22;
    @(posedge ACLK); #1;
    S_TDATA = 32'h33;
    @(negedge ACLK);
    n_total++; if (S_TREADY !== 1'b0 || M_TVALID !== 1'b1 || M_TDATA !== 32'h11) $display("FAIL bp_full: got rdy=%b vld=%b data=%h want 0/1/11", S_TREADY, M_TVALID, M_TDATA); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      @(negedge ACLK);
      n_total++; if (S_TREADY !== 1'b0 || M_TDATA !== 32'h11) $display("FAIL bp_hold%0d: got rdy=%b data=%h want 0/11", i, S_TREADY, M_TDATA); else n_pass++;
    end
    @(posedge ACLK); #1;
    M_TREADY = 1'b1;
    @(negedge ACLK);
    n_total++; if (M_TVALID !== 1'b1 || M_TDATA !== 32'h11 || S_TREADY !== 1'b0) $display("FAIL bp_out11: got vld=%b data=%h rdy=%b want 1/11/0", M_TVALID, M_TDATA, S_TREADY); else n_pass++;
    @(negedge ACLK);
    n_total++; if (M_TVALID !== 1'b1 || M_TDATA !== 32'h22 || S_TREADY !== 1'b1) $display("FAIL bp_out22: got vld=%b data=%h rdy=%b want 1/22/1", M_TVALID, M_TDATA, S_TREADY); else n_pass++;
    @(posedge ACLK); #1;
    S_TVALID = 1'b0;
    @(negedge ACLK);
    n_total++; if (M_TVALID !== 1'b1 || M_TDATA !== 32'h33) $display("FAIL bp_out33: got vld=%b data=%h want 1/33", M_TVALID, M_TDATA); else n_pass++;
    @(negedge ACLK);
    n_total++; if (M_TVALID !== 1'b0 || M_TDATA !== 32'h33) $display("FAIL bp_idle_hold: got vld=%b data=%h want 0/33", M_TVALID, M_TDATA); else n_pass++;
  endtask

  task automatic test_reset_in_full();
    int stale;
    stale = 0;
    @(posedge ACLK); #1;
    M_TREADY = 1'b0;
    S_TVALID = 1'b1;
    S_TDATA  = 32'h44;
    @(posedge ACLK); #1;
    S_TDATA = 32'h55;
    @(posedge ACLK); #1;
    S_TDATA = 32'h66;
    @(negedge ACLK);
    n_total++; if (S_TREADY !== 1'b0 || M_TVALID !== 1'b1 || M_TDATA !== 32'h44) $display("FAIL rst_pre_full: got rdy=%b vld=%b data=%h want 0/1/44", S_TREADY, M_TVALID, M_TDATA); else n_pass++;
    #2;
    ARESETn = 1'b0;
    #1;
    n_total++; if (M_TVALID !== 1'b0 || S_TREADY !== 1'b0) $display("FAIL rst_async: got vld=%b rdy=%b want 0/0", M_TVALID, S_TREADY); else n_pass++;
    n_total++; if (M_TDATA !== 32'h0) $display("FAIL rst_async_data: got %h want 0", M_TDATA); else n_pass++;
    S_TVALID = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    ARESETn  = 1'b1;
    M_TREADY = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge ACLK);
      if (M_TVALID !== 1'b0) stale++;
    end
    n_total++; if (stale !== 0) $display("FAIL rst_stale: got %0d valid cycles want 0", stale); else n_pass++;
    n_total++; if (S_TREADY !== 1'b1) $display("FAIL rst_ready_back: got %b want 1", S_TREADY); else n_pass++;
  endtask

`ifdef AXIS_REG_SLICE_STATS_EN
  task automatic test_stats();
    int sent;
    sent = 0;
    n_total++; if (beat_cnt !== 4'd0 || pkt_cnt !== 4'd0) $display("FAIL stats_start: got %0d/%0d want 0/0", beat_cnt, pkt_cnt); else n_pass++;
    M_TREADY = 1'b1;
    @(posedge ACLK); #1;
    S_TVALID = 1'b1;
    S_TDATA  = 32'(sent);
    S_TLAST  = ((sent % 4) == 3);
    for (int cyc = 0; cyc < 60 && sent < 20; cyc++) begin
      @(negedge ACLK);
      if (S_TVALID && S_TREADY) sent++;
      @(posedge ACLK); #1;
      if (sent < 20) begin
        S_TDATA = 32'(sent);
        S_TLAST = ((sent % 4) == 3);
      end else begin
        S_TVALID = 1'b0;
        S_TLAST  = 1'b0;
      end
    end
    repeat (4) @(negedge ACLK);
    n_total++; if (sent !== 20) $display("FAIL stats_sent: got %0d want 20", sent); else n_pass++;
    n_total++; if (beat_cnt !== 4'd15) $display("FAIL stats_beat_cnt: got %0d want 15", beat_cnt); else n_pass++;
    n_total++; if (pkt_cnt !== 4'd5) $display("FAIL stats_pkt_cnt: got %0d want 5", pkt_cnt); else n_pass++;
  endtask
`endif

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_first_beat();
    test_stream();
    test_backpressure();
    test_reset_in_full();
`ifdef AXIS_REG_SLICE_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
